// File: rtl/up_xfer_engine_if.sv
// Read and write request/grant bus between the transfer engine (master)
// and the memory side (slave). Addresses are word addresses.
interface up_xfer_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  rd_req_o;
  logic [ADDR_WIDTH-3:0] rd_word_addr_o;
  logic [DATA_WIDTH-1:0] rd_data_i;
  logic                  rd_gnt_i;
  logic                  wt_req_o;
  logic [ADDR_WIDTH-3:0] wt_word_addr_o;
  logic [DATA_WIDTH-1:0] wt_data_o;
  logic                  wt_gnt_i;

  modport master (
    output rd_req_o, rd_word_addr_o,
    input  rd_data_i, rd_gnt_i,
    output wt_req_o, wt_word_addr_o, wt_data_o,
    input  wt_gnt_i
  );

  modport slave (
    input  rd_req_o, rd_word_addr_o,
    output rd_data_i, rd_gnt_i,
    input  wt_req_o, wt_word_addr_o, wt_data_o,
    output wt_gnt_i
  );
endinterface

// File: rtl/up_xfer_engine.sv
// Word-copy engine: reads N words, applies a per-word transform, buffers them
// in a small FIFO and writes them out, with abort, status and interrupt.
module up_xfer_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [SIZE_WIDTH-1:0] size_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  input  logic                  ctrl_int_en_i,
  input  logic                  cmd_trigger_pulse_i,
  input  logic                  cmd_abort_pulse_i,
  input  logic                  cmd_clr_int_pulse_i,
  up_xfer_engine_if.master      bus,
  output logic                  status_busy_o,
  output logic                  status_int_pending_o,
  output logic                  status_aborted_o,
  output logic                  int_o,
  output logic [SIZE_WIDTH-3:0] remaining_o
);
  localparam int AW = ADDR_WIDTH - 2;
  localparam int NW = SIZE_WIDTH - 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [AW-1:0]         r_rd_addr;
  logic [AW-1:0]         r_wt_addr;
  logic [NW-1:0]         r_rd_left;
  logic [NW-1:0]         r_remaining;
  logic [1:0]            r_mode;
  logic [DATA_WIDTH-1:0] r_operand;
  logic [DATA_WIDTH-1:0] r_wt_data;
  logic                  r_rd_req;
  logic                  r_wt_req;
  logic                  r_aborted;
  logic                  r_int_pending;
  logic                  r_busy_q;
  logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic [NW-1:0]         w_n;
  logic                  w_rd_gnt;
  logic                  w_wt_gnt;
  logic                  w_last_wt;
  logic                  w_rd_hold;
  logic                  w_wt_hold;
  logic                  w_accept;
  logic                  w_abort_done;
  logic                  w_issue_rd;
  logic                  w_issue_wt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic [DATA_WIDTH-1:0] w_proc_data;
  logic                  w_unused;

  // Byte-offset bits of addresses and size carry no meaning for word transfers.
  assign w_unused = ^{src_addr_i[1:0], dst_addr_i[1:0], size_i[1:0]};

  assign w_n       = size_i[SIZE_WIDTH-1:2];
  assign w_rd_gnt  = r_rd_req & bus.rd_gnt_i;
  assign w_wt_gnt  = r_wt_req & bus.wt_gnt_i;
  assign w_last_wt = w_wt_gnt & (r_remaining == NW'(1));
  assign w_rd_hold = r_rd_req & ~bus.rd_gnt_i;
  assign w_wt_hold = r_wt_req & ~bus.wt_gnt_i;

  always_comb begin
    w_proc_data = bus.rd_data_i;
    case (r_mode)
      2'd1:    w_proc_data = {bus.rd_data_i[DATA_WIDTH-2:0], 1'b0};
      2'd2:    w_proc_data = ~bus.rd_data_i;
      2'd3:    w_proc_data = bus.rd_data_i + r_operand;
      default: w_proc_data = bus.rd_data_i;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_abort_done = 1'b0;
    w_issue_rd   = 1'b0;
    w_issue_wt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_trigger_pulse_i && (w_n != '0)) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        // The final write completing beats a simultaneous abort.
        if (w_last_wt) begin
          w_state_next = S_IDLE;
        end else if (cmd_abort_pulse_i) begin
          if (w_rd_hold || w_wt_hold) begin
            w_state_next = S_ABORT;
          end else begin
            w_state_next = S_IDLE;
            w_abort_done = 1'b1;
          end
        end else begin
          w_issue_rd = ~r_rd_req & (r_rd_left != '0) & (r_count < DEPTH_C);
          w_issue_wt = ~r_wt_req & (r_count != '0);
        end
      end
      S_ABORT: begin
        if (w_last_wt) begin
          w_state_next = S_IDLE;
        end else if (!w_rd_hold && !w_wt_hold) begin
          w_state_next = S_IDLE;
          w_abort_done = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_flush = (r_state != S_IDLE) && (w_state_next == S_IDLE);
  assign w_push  = w_rd_gnt && (r_state == S_RUN) && !w_flush;
  assign w_pop   = w_wt_gnt;

  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_proc_data;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rd_addr     <= '0;
      r_wt_addr     <= '0;
      r_rd_left     <= '0;
      r_remaining   <= '0;
      r_mode        <= '0;
      r_operand     <= '0;
      r_wt_data     <= '0;
      r_rd_req      <= 1'b0;
      r_wt_req      <= 1'b0;
      r_aborted     <= 1'b0;
      r_int_pending <= 1'b0;
      r_busy_q      <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_busy_q <= status_busy_o;
      if (w_accept) begin
        r_rd_addr   <= src_addr_i[ADDR_WIDTH-1:2];
        r_wt_addr   <= dst_addr_i[ADDR_WIDTH-1:2];
        r_rd_left   <= w_n;
        r_remaining <= w_n;
        r_mode      <= mode_i;
        r_operand   <= operand_i;
        r_aborted   <= 1'b0;
      end
      if (w_rd_gnt) begin
        r_rd_addr <= r_rd_addr + AW'(1);
        r_rd_left <= r_rd_left - NW'(1);
      end
      if (w_wt_gnt) begin
        r_wt_addr   <= r_wt_addr + AW'(1);
        r_remaining <= r_remaining - NW'(1);
      end
      // A request stays up until granted, then drops for at least one cycle.
      r_rd_req <= w_issue_rd | w_rd_hold;
      r_wt_req <= w_issue_wt | w_wt_hold;
      if (w_issue_wt) begin
        r_wt_data <= r_fifo[r_rd_ptr];
      end
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
      if (w_abort_done) begin
        r_aborted <= 1'b1;
      end
      // Busy-fall sets the interrupt even if a clear arrives in the same cycle.
      if (r_busy_q && !status_busy_o) begin
        r_int_pending <= 1'b1;
      end else if (cmd_clr_int_pulse_i) begin
        r_int_pending <= 1'b0;
      end
    end
  end

  assign bus.rd_req_o       = r_rd_req;
  assign bus.rd_word_addr_o = r_rd_addr;
  assign bus.wt_req_o       = r_wt_req;
  assign bus.wt_word_addr_o = r_wt_addr;
  assign bus.wt_data_o      = r_wt_data;

  assign status_busy_o        = (r_state != S_IDLE);
  assign status_int_pending_o = r_int_pending;
  assign status_aborted_o     = r_aborted;
  assign int_o                = ctrl_int_en_i & r_int_pending;
  assign remaining_o          = r_remaining;
endmodule

// File: tb/tb_up_xfer_engine.sv
// Directed and randomized checks of up_xfer_engine against a queue-based
// reference of the expected read/write streams.
module tb_up_xfer_engine;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 16;
  localparam int FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic [31:0]   src_addr, dst_addr, operand;
  logic [15:0]   size;
  logic [1:0]    mode;
  logic          int_en, cmd_trig, cmd_abort, cmd_clr;
  logic          busy, int_pend, aborted, int_out;
  logic [13:0]   remaining;

  up_xfer_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  up_xfer_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_WIDTH(SW), .FIFO_DEPTH(FD)
  ) dut (
    .ACLK                (clk),
    .ARESET              (areset),
    .src_addr_i          (src_addr),
    .dst_addr_i          (dst_addr),
    .size_i              (size),
    .mode_i              (mode),
    .operand_i           (operand),
    .ctrl_int_en_i       (int_en),
    .cmd_trigger_pulse_i (cmd_trig),
    .cmd_abort_pulse_i   (cmd_abort),
    .cmd_clr_int_pulse_i (cmd_clr),
    .bus                 (bus),
    .status_busy_o       (busy),
    .status_int_pending_o(int_pend),
    .status_aborted_o    (aborted),
    .int_o               (int_out),
    .remaining_o         (remaining)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [29:0] rd_a_q[$];
  logic [29:0] wt_a_q[$];
  logic [31:0] rd_d_q[$];
  logic [31:0] wt_d_q[$];
  int          rd_lat_min, rd_lat_max, wt_lat_min, wt_lat_max;
  int          rd_age, wt_age, rd_lat, wt_lat;
  bit          rd_block, wt_block, fixed_en, rd_gnt_prev, wt_gnt_prev;
  logic [31:0] fixed_data;
  int          last_wt_gnt_cyc;

  logic [1:0]  dm_tab[3]   = '{2'd3, 2'd1, 2'd2};
  logic [31:0] dd_tab[3]   = '{32'hFFFF_FFFF, 32'h8000_0001, 32'h0F0F_0F0F};
  logic [31:0] dexp_tab[3] = '{32'h0000_0000, 32'h0000_0002, 32'hF0F0_F0F0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xform(input logic [1:0] m, input logic [31:0] d,
                                        input logic [31:0] op);
    case (m)
      2'd0:    return d;
      2'd1:    return d << 1;
      2'd2:    return ~d;
      default: return d + op;
    endcase
  endfunction

  // One clock: memory-side responses are decided at the falling edge.
  task automatic tick();
    bus.rd_gnt_i  = 1'b0;
    bus.wt_gnt_i  = 1'b0;
    bus.rd_data_i = $urandom();
    if (bus.rd_req_o === 1'b1 && !rd_block) begin
      if (rd_age >= rd_lat) begin
        bus.rd_gnt_i = 1'b1;
        if (fixed_en) bus.rd_data_i = fixed_data;
        rd_a_q.push_back(bus.rd_word_addr_o);
        rd_d_q.push_back(bus.rd_data_i);
        rd_age = 0;
        rd_lat = int'($urandom_range(rd_lat_max, rd_lat_min));
      end else begin
        rd_age++;
      end
    end
    if (bus.wt_req_o === 1'b1 && !wt_block) begin
      if (wt_age >= wt_lat) begin
        bus.wt_gnt_i = 1'b1;
        wt_a_q.push_back(bus.wt_word_addr_o);
        wt_d_q.push_back(bus.wt_data_o);
        last_wt_gnt_cyc = cyc;
        wt_age = 0;
        wt_lat = int'($urandom_range(wt_lat_max, wt_lat_min));
      end else begin
        wt_age++;
      end
    end
    rd_gnt_prev = bus.rd_gnt_i;
    wt_gnt_prev = bus.wt_gnt_i;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    cmd_trig  = 1'b0;
    cmd_abort = 1'b0;
    cmd_clr   = 1'b0;
    if (rd_gnt_prev) check("rd_req_drop", 64'(bus.rd_req_o), 64'd0);
    if (wt_gnt_prev) check("wt_req_drop", 64'(bus.wt_req_o), 64'd0);
  endtask

  task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] sz, input logic [1:0] m, input logic [31:0] op);
    rd_a_q.delete(); rd_d_q.delete(); wt_a_q.delete(); wt_d_q.delete();
    rd_age = 0; wt_age = 0;
    rd_lat = int'($urandom_range(rd_lat_max, rd_lat_min));
    wt_lat = int'($urandom_range(wt_lat_max, wt_lat_min));
    src_addr = src; dst_addr = dst; size = sz; mode = m; operand = op;
    cmd_trig = 1'b1;
    tick();
    check("busy_on_trigger", 64'(busy), 64'd1);
    check("aborted_cleared", 64'(aborted), 64'd0);
    check("remaining_loaded", 64'(remaining), 64'(sz >> 2));
  endtask

  task automatic finish_xfer(input logic [31:0] src, input logic [31:0] dst,
                             input logic [15:0] sz, input logic [1:0] m, input logic [31:0] op,
                             input bit clr_at_fall, input bit poke);
    int n;
    int budget;
    logic [29:0] ea;
    n = int'(sz >> 2);
    budget = 0;
    while (busy === 1'b1 && budget < 4000) begin
      if (poke && budget == 2) begin
        src_addr = ~src; size = 16'h0040; cmd_trig = 1'b1;
      end
      tick();
      budget++;
    end
    check("xfer_done", 64'(busy), 64'd0);
    check("busy_fall_timing", 64'(cyc), 64'(last_wt_gnt_cyc + 1));
    check("int_not_yet", 64'(int_pend), 64'd0);
    if (clr_at_fall) cmd_clr = 1'b1;
    tick();
    check("int_pending_set", 64'(int_pend), 64'd1);
    check("int_o", 64'(int_out), 64'(int_en));
    cmd_clr = 1'b1;
    tick();
    check("int_cleared", 64'(int_pend), 64'd0);
    check("read_count", 64'(rd_a_q.size()), 64'(n));
    check("write_count", 64'(wt_a_q.size()), 64'(n));
    for (int i = 0; i < n && i < rd_a_q.size() && i < wt_a_q.size(); i++) begin
      ea = src[31:2] + 30'(i);
      check("rd_addr", 64'(rd_a_q[i]), 64'(ea));
      ea = dst[31:2] + 30'(i);
      check("wt_addr", 64'(wt_a_q[i]), 64'(ea));
      check("wt_data", 64'(wt_d_q[i]), 64'(xform(m, rd_d_q[i], op)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t_src, t_dst, t_op;
    logic [15:0] t_sz;
    logic [1:0]  t_m;
    areset = 1'b1; src_addr = '0; dst_addr = '0; size = '0; mode = '0; operand = '0;
    int_en = 1'b1; cmd_trig = 1'b0; cmd_abort = 1'b0; cmd_clr = 1'b0;
    bus.rd_gnt_i = 1'b0; bus.wt_gnt_i = 1'b0; bus.rd_data_i = '0;
    rd_lat_min = 0; rd_lat_max = 0; wt_lat_min = 0; wt_lat_max = 0;
    rd_block = 1'b0; wt_block = 1'b0; fixed_en = 1'b0; fixed_data = '0;
    rd_age = 0; wt_age = 0; rd_lat = 0; wt_lat = 0; last_wt_gnt_cyc = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_req", 64'(bus.rd_req_o), 64'd0);
    check("rst_wt_req", 64'(bus.wt_req_o), 64'd0);
    check("rst_remaining", 64'(remaining), 64'd0);
    check("rst_int_pend", 64'(int_pend), 64'd0);
    check("rst_aborted", 64'(aborted), 64'd0);
    check("rst_int_o", 64'(int_out), 64'd0);
    check("rst_wt_data", 64'(bus.wt_data_o), 64'd0);
    check("rst_rd_addr", 64'(bus.rd_word_addr_o), 64'd0);
    areset = 1'b0;
    tick();

    // Zero-length trigger is ignored.
    src_addr = 32'h100; size = 16'd3; cmd_trig = 1'b1;
    tick();
    check("zero_len_ignored", 64'(busy), 64'd0);

    // Copy with one-cycle grant latency.
    rd_lat_min = 1; rd_lat_max = 1; wt_lat_min = 1; wt_lat_max = 1;
    start_xfer(32'h100, 32'h200, 16'd16, 2'd0, 32'd0);
    finish_xfer(32'h100, 32'h200, 16'd16, 2'd0, 32'd0, 1'b0, 1'b0);
    check("copy_first_waddr", 64'(wt_a_q[0]), 64'h80);
    check("copy_last_waddr", 64'(wt_a_q[3]), 64'h83);

    // Transform corner values.
    rd_lat_min = 0; rd_lat_max = 2; wt_lat_min = 0; wt_lat_max = 2;
    fixed_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fixed_data = dd_tab[k];
      start_xfer(32'h400, 32'h800, 16'd4, dm_tab[k], 32'd1);
      finish_xfer(32'h400, 32'h800, 16'd4, dm_tab[k], 32'd1, 1'b0, 1'b0);
      check("mode_corner", 64'(wt_d_q[0]), 64'(dexp_tab[k]));
    end
    fixed_en = 1'b0;

    // Randomized transfers; odd ones re-trigger while busy, one clears at busy-fall.
    for (int k = 0; k < 6; k++) begin
      rd_lat_max = int'($urandom_range(3, 0));
      wt_lat_max = int'($urandom_range(3, 0));
      t_src = $urandom(); t_dst = $urandom(); t_op = $urandom();
      t_sz = 16'($urandom_range(64, 4));
      t_m = 2'($urandom_range(3, 0));
      int_en = 1'($urandom_range(1, 0));
      start_xfer(t_src, t_dst, t_sz, t_m, t_op);
      finish_xfer(t_src, t_dst, t_sz, t_m, t_op, (k == 2), (k % 2 == 1));
    end
    int_en = 1'b1;

    // Address wrap at the top of the word space.
    start_xfer(32'hFFFF_FFFC, 32'hFFFF_FFF8, 16'd8, 2'd0, 32'd0);
    finish_xfer(32'hFFFF_FFFC, 32'hFFFF_FFF8, 16'd8, 2'd0, 32'd0, 1'b0, 1'b0);
    check("wrap_rd0", 64'(rd_a_q[0]), 64'h3FFF_FFFF);
    check("wrap_rd1", 64'(rd_a_q[1]), 64'h0);

    // Write backpressure fills the buffer and stalls reads.
    rd_lat_max = 0; wt_lat_max = 0;
    wt_block = 1'b1;
    start_xfer(32'h1000, 32'h2000, 16'd32, 2'd2, 32'd0);
    repeat (30) tick();
    check("bp_reads", 64'(rd_a_q.size()), 64'd4);
    check("bp_rd_req_low", 64'(bus.rd_req_o), 64'd0);
    check("bp_wt_req_high", 64'(bus.wt_req_o), 64'd1);
    check("bp_remaining", 64'(remaining), 64'd8);
    wt_block = 1'b0;
    finish_xfer(32'h1000, 32'h2000, 16'd32, 2'd2, 32'd0, 1'b0, 1'b0);

    // Abort with a read request outstanding.
    rd_block = 1'b1;
    start_xfer(32'h3000, 32'h4000, 16'd32, 2'd0, 32'd0);
    repeat (3) tick();
    check("ab_rd_req_up", 64'(bus.rd_req_o), 64'd1);
    cmd_abort = 1'b1;
    tick();
    check("ab_busy_hold", 64'(busy), 64'd1);
    check("ab_rd_req_hold", 64'(bus.rd_req_o), 64'd1);
    repeat (2) tick();
    rd_block = 1'b0; rd_age = 0; rd_lat = 0;
    tick();
    check("ab_rd_req_drop", 64'(bus.rd_req_o), 64'd0);
    check("ab_busy_low", 64'(busy), 64'd0);
    check("ab_aborted", 64'(aborted), 64'd1);
    check("ab_remaining", 64'(remaining), 64'd8);
    check("ab_no_writes", 64'(wt_a_q.size()), 64'd0);
    tick();
    check("ab_int_pend", 64'(int_pend), 64'd1);
    check("ab_int_o", 64'(int_out), 64'd1);
    repeat (4) begin
      tick();
      check("ab_quiet_rd", 64'(bus.rd_req_o), 64'd0);
      check("ab_quiet_wt", 64'(bus.wt_req_o), 64'd0);
    end

    // Abort in idle changes nothing; clear drops the interrupt.
    cmd_abort = 1'b1;
    tick();
    check("idle_abort_aborted", 64'(aborted), 64'd1);
    check("idle_abort_busy", 64'(busy), 64'd0);
    check("idle_abort_int", 64'(int_pend), 64'd1);
    cmd_clr = 1'b1;
    tick();
    check("idle_clr_int", 64'(int_pend), 64'd0);

    // Reset in the middle of a transfer.
    rd_lat_max = 2; wt_lat_max = 2;
    start_xfer(32'h5000, 32'h6000, 16'd64, 2'd3, 32'd5);
    repeat (6) tick();
    areset = 1'b1;
    tick();
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rd_req", 64'(bus.rd_req_o), 64'd0);
    check("mid_rst_wt_req", 64'(bus.wt_req_o), 64'd0);
    check("mid_rst_remaining", 64'(remaining), 64'd0);
    check("mid_rst_aborted", 64'(aborted), 64'd0);
    check("mid_rst_int", 64'(int_pend), 64'd0);
    check("mid_rst_wt_data", 64'(bus.wt_data_o), 64'd0);
    check("mid_rst_wt_addr", 64'(bus.wt_word_addr_o), 64'd0);
    areset = 1'b0;
    tick();
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
